calc_port_scheduler: RTL and testbench
======================================

# calc_port_scheduler

Front-end scheduler for the calculator: accepts two-cycle command/operand transactions on four independent requester ports, holds one outstanding request per port, and shares a single ALU among the ports by round-robin arbitration. Each result is returned on the originating port's response/data outputs as a one-cycle pulse. Sits between the four requester interfaces and the shared arithmetic datapath.

## Interface
- DATA_W, 32, operand/result width
- SHIFT_W, 5, shift-amount bits taken from the low end of operand 2
- c_clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- reqN_cmd_in  in  4  command for port N (N=1..4); sampled only in the first cycle of a transaction
- reqN_data_in  in  DATA_W  operand 1 in the command cycle, operand 2 in the following cycle
- out_respN  out  2  response for port N: 0 none, 1 success, 2 error, 3 unused (never driven)
- out_dataN  out  DATA_W  result for port N; 0 whenever out_respN is not 1

## Operation
- Command codes: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all other codes are invalid.
- Per-port FSM:
  - IDLE: nonzero cmd → latch cmd and operand 1 → OP2.
  - OP2: latch reqN_data_in as operand 2; cmd input is ignored → PEND.
  - PEND: wait for grant; granted → EXEC.
  - EXEC: response driven this cycle; nonzero cmd accepted as a new transaction → OP2, else → IDLE.
- A nonzero cmd while a port is in OP2 or PEND is a protocol violation: ignored, with no response.
- Arbiter: each cycle grants at most one PEND port. Round-robin search starts at the port after the last granted; after reset the search order is 1,2,3,4.
- Invalid commands are still arbitrated so per-port ordering holds. Result is resp 2, data 0.
- ALU rules, unsigned DATA_W arithmetic:
  - Add: carry out of the MSB → resp 2, data 0; else resp 1 and the sum.
  - Subtract: operand 2 > operand 1 → resp 2, data 0; else resp 1 and the difference. Equal operands → resp 1, data 0.
  - Shifts: amount = low SHIFT_W bits of operand 2; zero fill; always resp 1.
- ALU result and flags are registered once, at the grant edge.

## Timing
- Reset (checked at the clock edge): all FSMs → IDLE, pending requests discarded without response, RR pointer → port 1, all out_respN/out_dataN = 0 from the cycle after the reset edge.
- Uncontended latency: cmd in cycle T, operand 2 in T+1, PEND and granted in T+2, response valid in T+3 only.
- out_respN/out_dataN are nonzero for exactly one cycle per accepted transaction.
- Throughput: one grant per cycle across all ports. One port alone sustains one transaction per 3 cycles by issuing its next cmd in its EXEC cycle.
- All four ports issuing cmd in the same cycle T: responses on ports 1,2,3,4 in cycles T+3,T+4,T+5,T+6.
- The RR pointer advances only on a grant; with no PEND port it holds.
- Reset asserted in the same cycle as a grant: the grant is cancelled and no response is produced.

## Structure
- Shared package calc_pkg: command encodings, response encodings, port count (4), per-port FSM state enum, DATA_W/SHIFT_W defaults.
- Sub-module calc_alu: combinational op + operands → result + error flag. The scheduler owns the output register.
- Arbiter and per-port FSMs live in the top level, with one generate loop over the ports.

## Test plan
- Port 1: add 0x0000_0001 + 0x01FF_FFFF at T/T+1 → out_resp1=1, out_data1=0x0200_0000 in T+3 only; other ports silent.
- Port 1: add 0xFFFF_FFFF + 1 → resp 2, data 0. Subtract 1 − 0xF → resp 2, data 0. Subtract 5 − 5 → resp 1, data 0.
- Port 3: cmd 3, then cmd 4 → resp 2, data 0 each. Shift-left 0x1 by 0x21 → resp 1, data 0x2 (amount 1).
- All four ports add i+i at the same T → port N gets resp 1, data 2N in cycle T+2+N. Then ports 1 and 2 requesting continuously → grants alternate 1,2,1,2.
- Port 2 in PEND behind port 1; reset pulsed for one cycle → no port 2 response; after reset, ports 4 and 1 requesting together → port 1 granted first.
- Port 1 issues a new cmd during OP2 → ignored, only the original response appears. A new cmd issued in the EXEC cycle → accepted, and its response arrives 3 cycles later.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings and defaults for the calculator port scheduler and its ALU.
package calc_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHIFT_W_DEF = 5;
  localparam int NPORTS      = 4;
  localparam int PORT_W      = $clog2(NPORTS);
  localparam int CMD_W       = 4;
  localparam int RESP_W      = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND,
    ST_EXEC
  } port_state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU shared by all ports: unsigned add/sub/shift with error flag.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o
);

  logic [DATA_W:0]    sum;
  logic [SHIFT_W-1:0] amt;

  assign sum = {1'b0, op1_i} + {1'b0, op2_i};
  assign amt = op2_i[SHIFT_W-1:0];

  // Any error leaves result_o at zero so the scheduler can register it directly.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (cmd_i)
      CMD_ADD: begin
        if (sum[DATA_W]) err_o = 1'b1;
        else             result_o = sum[DATA_W-1:0];
      end
      CMD_SUB: begin
        if (op2_i > op1_i) err_o = 1'b1;
        else               result_o = op1_i - op2_i;
      end
      CMD_SHL: result_o = op1_i << amt;
      CMD_SHR: result_o = op1_i >> amt;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_port_scheduler.sv
// Four-port request front end: per-port two-cycle capture FSMs sharing one ALU
// through a round-robin arbiter; results returned as one-cycle pulses.
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4
);

  logic [NPORTS-1:0][CMD_W-1:0]  cmd_in, cmd_all;
  logic [NPORTS-1:0][DATA_W-1:0] data_in, op1_all, op2_all, dout_all;
  logic [NPORTS-1:0][RESP_W-1:0] resp_all;
  logic [NPORTS-1:0]             pend, grant;

  logic [PORT_W-1:0] rr_q, gnt_idx, idx;
  logic              gnt_vld;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;
  logic [RESP_W-1:0] alu_resp;

  assign cmd_in  = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
  assign data_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

  // Round-robin search over pending ports starting at rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    idx     = rr_q;
    for (int k = 0; k < NPORTS; k++) begin
      idx = rr_q + PORT_W'(k);
      if (!gnt_vld && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign grant = gnt_vld ? (NPORTS'(1) << gnt_idx) : '0;

  always_ff @(posedge c_clk) begin
    if (reset)        rr_q <= '0;
    else if (gnt_vld) rr_q <= gnt_idx + PORT_W'(1);
  end

  calc_alu #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_alu (
    .cmd_i    (cmd_all[gnt_idx]),
    .op1_i    (op1_all[gnt_idx]),
    .op2_i    (op2_all[gnt_idx]),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  assign alu_resp = alu_err ? RESP_ERR : RESP_OK;

  for (genvar n = 0; n < NPORTS; n++) begin : g_port
    port_state_e       state_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] op1_q, op2_q, dout_q;
    logic [RESP_W-1:0] resp_q;
    logic              accept;

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_EXEC)) && (cmd_in[n] != CMD_NOP);

    always_ff @(posedge c_clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        resp_q  <= RESP_NONE;
        dout_q  <= '0;
      end else begin
        resp_q <= grant[n] ? alu_resp : RESP_NONE;
        dout_q <= grant[n] ? alu_result : '0;
        case (state_q)
          ST_IDLE, ST_EXEC: state_q <= accept ? ST_OP2 : ST_IDLE;
          ST_OP2:           state_q <= ST_PEND;
          ST_PEND:          if (grant[n]) state_q <= ST_EXEC;
          default:          state_q <= ST_IDLE;
        endcase
      end
    end

    // Operand capture needs no reset: it is only consumed after a fresh accept.
    always_ff @(posedge c_clk) begin
      if (accept) begin
        cmd_q <= cmd_in[n];
        op1_q <= data_in[n];
      end
      if (state_q == ST_OP2) op2_q <= data_in[n];
    end

    assign pend[n]     = (state_q == ST_PEND);
    assign cmd_all[n]  = cmd_q;
    assign op1_all[n]  = op1_q;
    assign op2_all[n]  = op2_q;
    assign resp_all[n] = resp_q;
    assign dout_all[n] = dout_q;
  end

  assign out_resp1 = resp_all[0];
  assign out_resp2 = resp_all[1];
  assign out_resp3 = resp_all[2];
  assign out_resp4 = resp_all[3];
  assign out_data1 = dout_all[0];
  assign out_data2 = dout_all[1];
  assign out_data3 = dout_all[2];
  assign out_data4 = dout_all[3];

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler: transaction-level model compared every
// cycle, plus literal expectations at known response cycles.
module tb_calc_port_scheduler;

  localparam int DW = 32;

  logic          c_clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd[4];
  logic [DW-1:0] dat[4];
  logic [1:0]    r1, r2, r3, r4;
  logic [DW-1:0] d1, d2, d3, d4;
  logic [1:0]    dr[4];
  logic [DW-1:0] dd[4];

  always #5 c_clk = ~c_clk;

  calc_port_scheduler dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req2_cmd_in  (cmd[1]),
    .req3_cmd_in  (cmd[2]),
    .req4_cmd_in  (cmd[3]),
    .req1_data_in (dat[0]),
    .req2_data_in (dat[1]),
    .req3_data_in (dat[2]),
    .req4_data_in (dat[3]),
    .out_resp1    (r1),
    .out_resp2    (r2),
    .out_resp3    (r3),
    .out_resp4    (r4),
    .out_data1    (d1),
    .out_data2    (d2),
    .out_data3    (d3),
    .out_data4    (d4)
  );

  assign dr[0] = r1;
  assign dr[1] = r2;
  assign dr[2] = r3;
  assign dr[3] = r4;
  assign dd[0] = d1;
  assign dd[1] = d2;
  assign dd[2] = d3;
  assign dd[3] = d4;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {resp, data} for one transaction, straight from the command rules.
  function automatic logic [33:0] golden(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    return {2'd1, a << b[4:0]};
      4'd6:    return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Transaction model: a port holds at most one outstanding request; it becomes
  // eligible two cycles after its command cycle; a grant yields the response in
  // the following cycle, during which the port may already take a new command.
  bit          busy[4];
  int          t_cyc[4];
  logic [3:0]  t_cmd[4];
  logic [31:0] t_op1[4], t_op2[4];
  int          rr = 0;
  int          cyc = 0;
  logic [1:0]  exp_r[4];
  logic [31:0] exp_d[4];

  always @(posedge c_clk) begin : model
    int g;
    int p;
    bit ob[4];
    logic [33:0] res;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        busy[i]  = 1'b0;
        exp_r[i] = 2'd0;
        exp_d[i] = '0;
      end
      rr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_r[i] = 2'd0;
        exp_d[i] = '0;
        ob[i]    = busy[i];
        if (busy[i] && cyc == t_cyc[i] + 1) t_op2[i] = dat[i];
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        p = (rr + k) % 4;
        if (g < 0 && busy[p] && cyc >= t_cyc[p] + 2) g = p;
      end
      if (g >= 0) begin
        res      = golden(t_cmd[g], t_op1[g], t_op2[g]);
        exp_r[g] = res[33:32];
        exp_d[g] = res[31:0];
        busy[g]  = 1'b0;
        rr       = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (!ob[i] && cmd[i] != 4'd0) begin
          busy[i]  = 1'b1;
          t_cyc[i] = cyc;
          t_cmd[i] = cmd[i];
          t_op1[i] = dat[i];
        end
      end
    end
    cyc++;
  end

  always @(negedge c_clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("resp%0d", i + 1), dr[i], exp_r[i]);
        chk($sformatf("data%0d", i + 1), dd[i], exp_d[i]);
      end
    end
  end

  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 4'd0;
      dat[i] = '0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic txn(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                     logic [1:0] er, logic [31:0] ed, string name);
    cmd[p] = c;
    dat[p] = a;
    tick();
    cmd[p] = 4'd0;
    dat[p] = b;
    tick();
    dat[p] = '0;
    tick();
    chk({name, "_resp"}, dr[p], er);
    chk({name, "_data"}, dd[p], ed);
    tick();
    chk({name, "_after"}, dr[p], 2'd0);
  endtask

  int order[$];

  initial begin
    idle_all();
    tick();
    tick();
    started = 1'b1;
    reset   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("reset_resp", dr[i], 2'd0);
      chk("reset_data", dd[i], 32'd0);
    end

    txn(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000, "add_basic");
    txn(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0, "add_carry");
    txn(0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0, "sub_borrow");
    txn(0, 4'd2, 32'd5, 32'd5, 2'd1, 32'd0, "sub_equal");
    txn(2, 4'd3, 32'd9, 32'd9, 2'd2, 32'd0, "inv_cmd3");
    txn(2, 4'd4, 32'd9, 32'd9, 2'd2, 32'd0, "inv_cmd4");
    txn(2, 4'd5, 32'h1, 32'h21, 2'd1, 32'h2, "shl_wrap");
    txn(1, 4'd6, 32'h8000_0000, 32'd4, 2'd1, 32'h0800_0000, "shr");

    // All four ports at once, pointer freshly reset.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 4'd1;
      dat[i] = 32'(i + 1);
    end
    tick();
    for (int i = 0; i < 4; i++) cmd[i] = 4'd0;
    tick();
    idle_all();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("all4_resp%0d", i + 1), dr[i], 2'd1);
      chk($sformatf("all4_data%0d", i + 1), dd[i], 32'(2 * (i + 1)));
      tick();
    end

    // Ports 1 and 2 hold their requests continuously.
    cmd[0] = 4'd1;
    dat[0] = 32'd3;
    cmd[1] = 4'd1;
    dat[1] = 32'd5;
    for (int n = 0; n < 14; n++) begin
      tick();
      for (int i = 0; i < 2; i++) if (dr[i] != 2'd0) order.push_back(i);
    end
    idle_all();
    for (int n = 0; n < 6; n++) tick();
    chk("alt_count_ok", (order.size() >= 4) ? 1 : 0, 1);
    if (order.size() >= 4) begin
      chk("alt_0", order[0], 0);
      chk("alt_1", order[1], 1);
      chk("alt_2", order[2], 0);
      chk("alt_3", order[3], 1);
    end

    // Reset lands on port 2's grant cycle.
    pulse_reset();
    cmd[0] = 4'd1;
    dat[0] = 32'd10;
    cmd[1] = 4'd1;
    dat[1] = 32'd20;
    tick();
    cmd[0] = 4'd0;
    cmd[1] = 4'd0;
    dat[0] = 32'd1;
    dat[1] = 32'd2;
    tick();
    idle_all();
    tick();
    chk("rst_p1_resp", dr[0], 2'd1);
    chk("rst_p1_data", dd[0], 32'd11);
    pulse_reset();
    for (int n = 0; n < 4; n++) begin
      chk("rst_p2_silent", dr[1], 2'd0);
      tick();
    end

    // Ports 4 and 1 together after reset: port 1 first.
    cmd[3] = 4'd1;
    dat[3] = 32'd100;
    cmd[0] = 4'd1;
    dat[0] = 32'd1;
    tick();
    cmd[3] = 4'd0;
    cmd[0] = 4'd0;
    dat[3] = 32'd200;
    dat[0] = 32'd2;
    tick();
    idle_all();
    tick();
    chk("p41_first_resp1", dr[0], 2'd1);
    chk("p41_first_data1", dd[0], 32'd3);
    chk("p41_first_resp4", dr[3], 2'd0);
    tick();
    chk("p41_second_resp4", dr[3], 2'd1);
    chk("p41_second_data4", dd[3], 32'd300);
    tick();

    // Command during OP2 ignored; command in EXEC accepted.
    cmd[0] = 4'd1;
    dat[0] = 32'd7;
    tick();
    cmd[0] = 4'd2;
    dat[0] = 32'd2;
    tick();
    idle_all();
    tick();
    chk("viol_resp", dr[0], 2'd1);
    chk("viol_data", dd[0], 32'd9);
    cmd[0] = 4'd2;
    dat[0] = 32'd20;
    tick();
    chk("exec_gap1", dr[0], 2'd0);
    cmd[0] = 4'd0;
    dat[0] = 32'd6;
    tick();
    chk("exec_gap2", dr[0], 2'd0);
    dat[0] = '0;
    tick();
    chk("exec_resp", dr[0], 2'd1);
    chk("exec_data", dd[0], 32'd14);
    tick();
    chk("exec_after", dr[0], 2'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
